ph_track_est_param: RTL and testbench
=====================================

Name: ph_track_est_param

Overview:
Parametrised pilot-based common-phase estimator for the OFDM RX, placed after the equaliser. Per symbol it accumulates sign-corrected pilot subcarriers selected by alloc_vec and averages them into a complex phase reference. It generalises the fixed 4-pilot estimator with:
- configurable width and pilot count
- saturation on the averaged output
- optional first-order IIR smoothing across symbols
- a per-symbol pilot-count check

Parameters:
DW, 16, sample width (two's complement, format inherited from input, e.g. Q3.13)
LOG2NP, 2, log2 of pilots per symbol (NP = 2^LOG2NP, legal 1..4)
ALPHA_SH, 2, IIR smoothing shift (alpha = 2^-ALPHA_SH, legal 1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  new frame: clear accumulation, re-enter acquisition
datin_val  in  1  input sample valid
datin_Re  in  DW  real sample
datin_Im  in  DW  imag sample
alloc_vec  in  2  01 = positive pilot, 10 = negative pilot, 00/11 = ignore
sym_end  in  1  qualifies the last sample of a symbol (used with datin_val)
smooth_en  in  1  1 = IIR smoothing after first estimate
ph_Re  out  DW  phase reference real, registered
ph_Im  out  DW  phase reference imag, registered
ph_oval  out  1  one-cycle pulse, new ph_Re/ph_Im valid
pilot_err  out  1  one-cycle pulse, symbol ended with pilot count != NP

Behaviour:
- Reset: ph_Re = ph_Im = 0, ph_oval = 0, pilot_err = 0, accumulators = 0, pilot counter = 0, state = ACQ.
- Pilot accept: pilot_acc = datin_val & (alloc_vec == 01 | alloc_vec == 10).
  - Sign-extend each component to AW = DW+LOG2NP+1 before use.
  - Negative pilot: negate in AW bits, so -2^(DW-1) becomes +2^(DW-1) exactly with no wrap.
- Accumulator: AW-bit real and imag registers, incremented on pilot_acc. Pilot counter is LOG2NP+1 bits.
- Symbol completion occurs on the accepting cycle when counter+1 == NP:
  - raw = acc_next >>> LOG2NP (arithmetic shift, truncate toward -inf).
  - raw saturates to [-2^(DW-1), 2^(DW-1)-1].
  - Accumulators and counter clear on the same edge.
- State machine, states ACQ and TRACK:
  - ACQ, completion: ph <= raw; go to TRACK.
  - TRACK, completion with smooth_en=0: ph <= raw.
  - TRACK, completion with smooth_en=1: ph <= ph + ((raw - ph) >>> ALPHA_SH), computed in DW+1 bits. This is a convex combination, so no saturation is needed.
  - start, from any state: go to ACQ.
- Latency: ph_Re/ph_Im and ph_oval are registered on the edge that accepts the NP-th pilot. They are visible the cycle after it and hold until the next completion.
- sym_end check (datin_val & sym_end):
  - Let count_incl = the counter value including the current sample if it is a pilot.
  - If count_incl == 0 (completion already cleared the counter, or NP pilots completed on this sample): no error.
  - Otherwise: pilot_err pulses the next cycle, accumulators and counter clear, no ph_oval, ph held, state unchanged.
  - A completion on the same sample as sym_end is legal.
- More than NP pilots in a symbol: the counter wraps into a new accumulation. The surplus is caught by the sym_end check.
- start has priority over everything:
  - It clears accumulators and counter and forces ACQ.
  - A sample arriving in the same cycle is dropped.
  - ph_Re/ph_Im hold their values; ph_oval and pilot_err are 0 that cycle.
- rst has priority over start.
- datin_val = 0: no state change, and alloc_vec is ignored.

Test Plan:
1. DW=16, NP=4, ACQ: Re pilots 0x1000,0x1000,0x1000 (01) then 0xF000 (10); Im all 0 -> ph_Re=0x1000, ph_Im=0, ph_oval pulses one cycle after the 4th pilot.
2. Saturation: four negative pilots with Re=0x8000 -> sum +131072 in 19 bits, raw 32768 saturates to ph_Re=0x7FFF; no wrap.
3. Smoothing, ALPHA_SH=2, smooth_en=1:
   - Symbol 1 averages 0x1000 -> ph_Re=0x1000.
   - Symbol 2 averages 0x2000 -> ph_Re=0x1400.
   - Symbol 3 with smooth_en=0 averaging 0x0800 -> ph_Re=0x0800.
4. Pilot check: 3 pilots then sym_end -> pilot_err pulse, no ph_oval, ph unchanged. The next symbol with 4 correct pilots produces the correct unbiased average.
5. start after 2 pilots in TRACK: accumulation discarded, ph held. The next 4 pilots (avg 0x0400) give ph_Re=0x0400 unsmoothed, because the block is back in ACQ.
6. rst mid-symbol, then alloc_vec=00/11 samples with datin_val=1 -> all outputs 0, no ph_oval, no pilot_err.

Source files
------------

// File: rtl/ph_track_est_param_if.sv
// Sample/result bus of the pilot-based common-phase estimator.
// The master drives equalised samples and control; the slave returns the phase reference.
interface ph_track_est_param_if #(
  parameter int DW = 16
);
  logic          start;
  logic          datin_val;
  logic [DW-1:0] datin_Re;
  logic [DW-1:0] datin_Im;
  logic [1:0]    alloc_vec;
  logic          sym_end;
  logic          smooth_en;
  logic [DW-1:0] ph_Re;
  logic [DW-1:0] ph_Im;
  logic          ph_oval;
  logic          pilot_err;

  modport master (
    output start, datin_val, datin_Re, datin_Im, alloc_vec, sym_end, smooth_en,
    input  ph_Re, ph_Im, ph_oval, pilot_err
  );

  modport slave (
    input  start, datin_val, datin_Re, datin_Im, alloc_vec, sym_end, smooth_en,
    output ph_Re, ph_Im, ph_oval, pilot_err
  );
endinterface

// File: rtl/ph_track_est_param.sv
// Pilot-based common-phase estimator: averages NP sign-corrected pilots per symbol,
// saturates the average and optionally IIR-smooths it across symbols.
module ph_track_est_param #(
  parameter int DW       = 16,
  parameter int LOG2NP   = 2,
  parameter int ALPHA_SH = 2
) (
  input logic                  clk,
  input logic                  rst,
  ph_track_est_param_if.slave  bus
);

  localparam int AW = DW + LOG2NP + 1;
  localparam int CW = LOG2NP + 1;
  localparam logic [CW-1:0] NP = CW'(1 << LOG2NP);
  localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {ACQ, TRACK} state_t;

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [DW-1:0]   ph_re_q, ph_re_d, ph_im_q, ph_im_d;
  logic                   oval_q, oval_d, err_q, err_d;

  logic                   pilot_acc, pilot_neg, complete, sym_err;
  logic [CW-1:0]          cnt_inc, count_incl;
  logic signed [AW-1:0]   smp_re, smp_im, sum_re, sum_im;
  logic signed [DW-1:0]   raw_re, raw_im;

  function automatic logic signed [DW-1:0] sat_avg(input logic signed [AW-1:0] sum);
    logic signed [AW-1:0] avg;
    avg = sum >>> LOG2NP;
    if (avg > SAT_MAX)      return SAT_MAX[DW-1:0];
    else if (avg < SAT_MIN) return SAT_MIN[DW-1:0];
    else                    return avg[DW-1:0];
  endfunction

  // One extra bit keeps raw - ph exact; the result lies between ph and raw, so it fits DW.
  function automatic logic signed [DW-1:0] smooth(input logic signed [DW-1:0] cur,
                                                  input logic signed [DW-1:0] tgt);
    logic signed [DW:0] diff, step, nxt;
    diff = {tgt[DW-1], tgt} - {cur[DW-1], cur};
    step = diff >>> ALPHA_SH;
    nxt  = {cur[DW-1], cur} + step;
    return nxt[DW-1:0];
  endfunction

  assign pilot_acc = bus.datin_val & ((bus.alloc_vec == 2'b01) | (bus.alloc_vec == 2'b10));
  assign pilot_neg = (bus.alloc_vec == 2'b10);

  // Negation happens after widening, so the most negative input becomes its exact positive.
  assign smp_re = pilot_neg ? -AW'(signed'(bus.datin_Re)) : AW'(signed'(bus.datin_Re));
  assign smp_im = pilot_neg ? -AW'(signed'(bus.datin_Im)) : AW'(signed'(bus.datin_Im));
  assign sum_re = acc_re_q + smp_re;
  assign sum_im = acc_im_q + smp_im;
  assign raw_re = sat_avg(sum_re);
  assign raw_im = sat_avg(sum_im);

  assign cnt_inc    = cnt_q + 1'b1;
  assign complete   = pilot_acc & (cnt_inc == NP);
  assign count_incl = pilot_acc ? cnt_inc : cnt_q;
  assign sym_err    = bus.datin_val & bus.sym_end & ~complete & (count_incl != '0);

  // NOTE: every variable gets its default first so no path through this block infers a latch.
  always_comb begin
    state_d  = state_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    cnt_d    = cnt_q;
    ph_re_d  = ph_re_q;
    ph_im_d  = ph_im_q;
    oval_d   = 1'b0;
    err_d    = 1'b0;

    if (bus.start) begin
      acc_re_d = '0;
      acc_im_d = '0;
      cnt_d    = '0;
      state_d  = ACQ;
    end else if (sym_err) begin
      acc_re_d = '0;
      acc_im_d = '0;
      cnt_d    = '0;
      err_d    = 1'b1;
    end else if (complete) begin
      acc_re_d = '0;
      acc_im_d = '0;
      cnt_d    = '0;
      oval_d   = 1'b1;
      state_d  = TRACK;
      if (state_q == TRACK && bus.smooth_en) begin
        ph_re_d = smooth(ph_re_q, raw_re);
        ph_im_d = smooth(ph_im_q, raw_im);
      end else begin
        ph_re_d = raw_re;
        ph_im_d = raw_im;
      end
    end else if (pilot_acc) begin
      acc_re_d = sum_re;
      acc_im_d = sum_im;
      cnt_d    = cnt_inc;
    end
  end

  // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACQ;
      acc_re_q <= '0;
      acc_im_q <= '0;
      cnt_q    <= '0;
      ph_re_q  <= '0;
      ph_im_q  <= '0;
      oval_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      cnt_q    <= cnt_d;
      ph_re_q  <= ph_re_d;
      ph_im_q  <= ph_im_d;
      oval_q   <= oval_d;
      err_q    <= err_d;
    end
  end

  assign bus.ph_Re     = ph_re_q;
  assign bus.ph_Im     = ph_im_q;
  assign bus.ph_oval   = oval_q;
  assign bus.pilot_err = err_q;

endmodule

// File: tb/tb_ph_track_est_param.sv
// Directed bench for ph_track_est_param (DW=16, NP=4, ALPHA_SH=2); each task checks
// the packed result {ph_Re, ph_Im, ph_oval, pilot_err} against hand-computed values.
module tb_ph_track_est_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [33:0] exp_v;

  always #5 clk = ~clk;

  ph_track_est_param_if #(.DW(16)) bus ();

  ph_track_est_param #(.DW(16), .LOG2NP(2), .ALPHA_SH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [33:0] obs();
    return {bus.ph_Re, bus.ph_Im, bus.ph_oval, bus.pilot_err};
  endfunction

  // One sample presented for one clock; outputs are sampled 1 time unit after the edge.
  task automatic sample(input logic [15:0] re, input logic [15:0] im,
                        input logic [1:0] alloc, input logic last);
    bus.datin_val = 1'b1;
    bus.datin_Re  = re;
    bus.datin_Im  = im;
    bus.alloc_vec = alloc;
    bus.sym_end   = last;
    @(posedge clk); #1;
    bus.datin_val = 1'b0;
    bus.alloc_vec = 2'b00;
    bus.sym_end   = 1'b0;
    bus.start     = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_v = {16'h0000, 16'h0000, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL reset_state: got %h want %h", obs(), exp_v);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_acq();
    for (int i = 0; i < 3; i++) begin
      sample(16'h1000, 16'h0000, 2'b01, 1'b0);
      checks++;
      if (bus.ph_oval !== 1'b0) begin
        errors++; $display("FAIL acq_early_oval: got %b want 0 at pilot %0d", bus.ph_oval, i);
      end
    end
    sample(16'hF000, 16'h0000, 2'b10, 1'b0);
    exp_v = {16'h1000, 16'h0000, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL acq_avg: got %h want %h", obs(), exp_v);
    end
    idle();
    exp_v = {16'h1000, 16'h0000, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL acq_hold: got %h want %h", obs(), exp_v);
    end
  endtask

  // Now in TRACK with smoothing off: raw average is used directly.
  task automatic test_saturation();
    bus.smooth_en = 1'b0;
    for (int i = 0; i < 4; i++) sample(16'h8000, 16'h7FFF, 2'b10, 1'b0);
    exp_v = {16'h7FFF, 16'h8001, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL sat_pos: got %h want %h", obs(), exp_v);
    end
  endtask

  task automatic test_smoothing();
    bus.start = 1'b1;
    idle();
    bus.start = 1'b0;
    bus.smooth_en = 1'b1;
    for (int i = 0; i < 4; i++) sample(16'h1000, 16'h0000, 2'b01, 1'b0);
    exp_v = {16'h1000, 16'h0000, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL smooth_sym1: got %h want %h", obs(), exp_v);
    end
    for (int i = 0; i < 4; i++) sample(16'h2000, 16'hF000, 2'b01, i == 3);
    exp_v = {16'h1400, 16'hFC00, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL smooth_sym2: got %h want %h", obs(), exp_v);
    end
    bus.smooth_en = 1'b0;
    for (int i = 0; i < 4; i++) sample(16'h0800, 16'h0000, 2'b01, 1'b0);
    exp_v = {16'h0800, 16'h0000, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL smooth_off_sym3: got %h want %h", obs(), exp_v);
    end
  endtask

  task automatic test_pilot_check();
    for (int i = 0; i < 3; i++) sample(16'h3000, 16'h0000, 2'b01, 1'b0);
    sample(16'h0000, 16'h0000, 2'b00, 1'b1);
    exp_v = {16'h0800, 16'h0000, 1'b0, 1'b1};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL short_sym_err: got %h want %h", obs(), exp_v);
    end
    sample(16'h0100, 16'h0000, 2'b01, 1'b0);
    exp_v = {16'h0800, 16'h0000, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL err_one_cycle: got %h want %h", obs(), exp_v);
    end
    // A pilot code without datin_val must not count.
    bus.alloc_vec = 2'b01;
    bus.datin_Re  = 16'h7000;
    idle();
    bus.alloc_vec = 2'b00;
    sample(16'h0200, 16'h0000, 2'b01, 1'b0);
    sample(16'h0300, 16'h0000, 2'b01, 1'b0);
    sample(16'h0600, 16'h0000, 2'b01, 1'b0);
    exp_v = {16'h0300, 16'h0000, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL recover_avg: got %h want %h", obs(), exp_v);
    end
    for (int i = 0; i < 4; i++) sample(16'h0200, 16'h0000, 2'b01, 1'b0);
    exp_v = {16'h0200, 16'h0000, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL surplus_first4: got %h want %h", obs(), exp_v);
    end
    sample(16'h7000, 16'h0000, 2'b01, 1'b1);
    exp_v = {16'h0200, 16'h0000, 1'b0, 1'b1};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL surplus_err: got %h want %h", obs(), exp_v);
    end
  endtask

  task automatic test_start();
    bus.smooth_en = 1'b1;
    sample(16'h4000, 16'h0000, 2'b01, 1'b0);
    sample(16'h4000, 16'h0000, 2'b01, 1'b0);
    bus.start = 1'b1;
    sample(16'h7000, 16'h0000, 2'b01, 1'b1);
    exp_v = {16'h0200, 16'h0000, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL start_hold: got %h want %h", obs(), exp_v);
    end
    for (int i = 0; i < 4; i++) sample(16'h0400, 16'h0000, 2'b01, 1'b0);
    exp_v = {16'h0400, 16'h0000, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL start_reacq: got %h want %h", obs(), exp_v);
    end
  endtask

  task automatic test_rst_mid();
    sample(16'h1000, 16'h1000, 2'b01, 1'b0);
    sample(16'h1000, 16'h1000, 2'b01, 1'b0);
    rst = 1'b1;
    sample(16'h1000, 16'h1000, 2'b01, 1'b0);
    rst = 1'b0;
    exp_v = {16'h0000, 16'h0000, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL rst_clear: got %h want %h", obs(), exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      sample(16'h1234, 16'h4321, (i == 1) ? 2'b11 : 2'b00, i == 2);
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL ignore_alloc_%0d: got %h want %h", i, obs(), exp_v);
      end
    end
    for (int i = 0; i < 4; i++) sample(16'h0100, 16'h0000, 2'b01, 1'b0);
    exp_v = {16'h0100, 16'h0000, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL rst_reacq: got %h want %h", obs(), exp_v);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.datin_val = 1'b0;
    bus.datin_Re  = '0;
    bus.datin_Im  = '0;
    bus.alloc_vec = 2'b00;
    bus.sym_end   = 1'b0;
    bus.smooth_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_acq();
    test_saturation();
    test_smoothing();
    test_pilot_check();
    test_start();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
